// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: register-number width, the
// architectural register count, and the hazard controller's state encoding.
package cpu_pkg;

  localparam int REG_W = 5;
  localparam int NREG  = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline stage registers and the hazard controller.
//   ID side   : id_valid, id_rj/id_use_rj, id_rs2/id_use_rs2, id_rf_we, id_rd
//   EXE side  : exe_br_taken
//   WB side   : wb_valid, wb_rf_we, wb_rd
//   Controls  : pc_hold, id_hold, exe_bubble, if_id_flush
//   Status    : stall_cnt, flush_cnt (PERF_W wide, wrapping), sb_err (sticky)
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int PERF_W = 32
);

  logic                       id_valid;
  logic [cpu_pkg::REG_W-1:0]  id_rj;
  logic                       id_use_rj;
  logic [cpu_pkg::REG_W-1:0]  id_rs2;
  logic                       id_use_rs2;
  logic                       id_rf_we;
  logic [cpu_pkg::REG_W-1:0]  id_rd;
  logic                       exe_br_taken;
  logic                       wb_valid;
  logic                       wb_rf_we;
  logic [cpu_pkg::REG_W-1:0]  wb_rd;

  logic                       pc_hold;
  logic                       id_hold;
  logic                       exe_bubble;
  logic                       if_id_flush;
  logic [PERF_W-1:0]          stall_cnt;
  logic [PERF_W-1:0]          flush_cnt;
  logic                       sb_err;

  modport master (
    output id_valid, id_rj, id_use_rj, id_rs2, id_use_rs2, id_rf_we, id_rd,
    output exe_br_taken, wb_valid, wb_rf_we, wb_rd,
    input  pc_hold, id_hold, exe_bubble, if_id_flush,
    input  stall_cnt, flush_cnt, sb_err
  );

  modport slave (
    input  id_valid, id_rj, id_use_rj, id_rs2, id_use_rs2, id_rf_we, id_rd,
    input  exe_br_taken, wb_valid, wb_rf_we, wb_rd,
    output pc_hold, id_hold, exe_bubble, if_id_flush,
    output stall_cnt, flush_cnt, sb_err
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight writer counters for the no-forwarding pipeline.
//   clk, rst        : clock, async active-high reset
//   inc_en/inc_rd   : a writer targeting inc_rd enters EXE this cycle
//   dec_en/dec_rd   : a writer targeting dec_rd leaves WB this cycle
//   rd_a/rd_b       : source register read ports
//   busy_a/busy_b   : source register has a pending writer (r0 never busy)
//   sb_err          : sticky counter overflow/underflow flag
module hazard_scoreboard #(
  parameter int NREG  = cpu_pkg::NREG,
  parameter int CNT_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inc_en,
  input  logic [cpu_pkg::REG_W-1:0] inc_rd,
  input  logic                      dec_en,
  input  logic [cpu_pkg::REG_W-1:0] dec_rd,
  input  logic [cpu_pkg::REG_W-1:0] rd_a,
  input  logic [cpu_pkg::REG_W-1:0] rd_b,
  output logic                      busy_a,
  output logic                      busy_b,
  output logic                      sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;

  // r0 is hard-wired zero, so it is filtered out of both decoders.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    inc_vec = '0;
    dec_vec = '0;
    if (inc_en && inc_rd != '0) inc_vec[inc_rd] = 1'b1;
    if (dec_en && dec_rd != '0) dec_vec[dec_rd] = 1'b1;
  end

  assign busy_a = (rd_a != '0) && (cnt[rd_a] != '0);
  assign busy_b = (rd_b != '0) && (cnt[rd_b] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the counter array must be reset -- a stale count would stall the pipe forever.
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        // A writer entering and one leaving on the same register cancel out.
        if (inc_vec[r] && !dec_vec[r]) begin
          if (cnt[r] == CNT_MAX) sb_err <= 1'b1;
          // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
          else                   cnt[r] <= cnt[r] + 1'b1;
        end else if (dec_vec[r] && !inc_vec[r]) begin
          if (cnt[r] == '0) sb_err <= 1'b1;
          else              cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock/flush controller for the 5-stage in-order pipeline without
// forwarding. Stalls PC and ID while a source register has an in-flight
// writer; squashes IF/ID when EXE resolves a taken branch (branch wins).
//   clk, rst : clock, async active-high reset
//   bus      : pipe_hazard_ctrl_if.slave (ID/EXE/WB inputs, hold/flush
//              controls, perf counters, sticky scoreboard error)
module pipe_hazard_ctrl #(
  parameter int NREG   = cpu_pkg::NREG,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  import cpu_pkg::*;

  state_t            state_q, state_d;
  logic              busy_rj, busy_rs2;
  logic              hazard, issue, retire;
  logic              hold, bubble, flush;
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  assign hazard = bus.id_valid & ((bus.id_use_rj & busy_rj) | (bus.id_use_rs2 & busy_rs2));
  assign issue  = bus.id_valid & ~hazard & ~bus.exe_br_taken;
  assign retire = bus.wb_valid & bus.wb_rf_we;

  hazard_scoreboard #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .inc_en (issue & bus.id_rf_we),
    .inc_rd (bus.id_rd),
    .dec_en (retire),
    .dec_rd (bus.wb_rd),
    .rd_a   (bus.id_rj),
    .rd_b   (bus.id_rs2),
    .busy_a (busy_rj),
    .busy_b (busy_rs2),
    .sb_err (bus.sb_err)
  );

  // Next state depends only on this cycle's decision, so RUN, STALL and
  // FLUSH share one transition rule; the state exists for perf accounting.
  always_comb begin
    state_d = RUN;
    hold    = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    if (bus.exe_br_taken) begin
      state_d = FLUSH;
      flush   = 1'b1;
      bubble  = 1'b1;
    end else if (hazard) begin
      state_d = STALL;
      hold    = 1'b1;
      bubble  = 1'b1;
    end
  end

  // Controls are forced low while reset is held, even if EXE reports a branch.
  assign bus.pc_hold     = hold   & ~rst;
  assign bus.id_hold     = hold   & ~rst;
  assign bus.exe_bubble  = bubble & ~rst;
  assign bus.if_id_flush = flush  & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == STALL) stall_cnt_q <= stall_cnt_q + 1'b1;
      // Counted on the edge that enters FLUSH, so back-to-back branches each count.
      if (state_d == FLUSH) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
